// File: rtl/dfh_pkg.sv
// DFH field layout, feature-type codes, result codes and walker FSM states.
package dfh_pkg;

    // Bit positions inside a 64-bit Device Feature Header word
    localparam int DFH_TYPE_LSB  = 60;
    localparam int DFH_MINOR_LSB = 48;
    localparam int DFH_EOL_BIT   = 40;
    localparam int DFH_NEXT_LSB  = 16;
    localparam int DFH_MAJOR_LSB = 12;
    localparam int DFH_ID_LSB    = 0;

    // Feature types; only AFU and BBB carry a GUID after the header
    localparam logic [3:0] FT_AFU     = 4'd1;
    localparam logic [3:0] FT_BBB     = 4'd2;
    localparam logic [3:0] FT_PRIVATE = 4'd3;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_BAD_LINK = 2'b10,
        ERR_TOO_MANY = 2'b11
    } err_e;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_HDR, S_WT_HDR, S_RD_IDL, S_WT_IDL,
        S_RD_IDH, S_WT_IDH, S_EMIT, S_FIN
    } state_e;

    function automatic logic [3:0] dfh_type(input logic [63:0] h);
        return h[DFH_TYPE_LSB +: 4];
    endfunction

    function automatic logic [3:0] dfh_minor(input logic [63:0] h);
        return h[DFH_MINOR_LSB +: 4];
    endfunction

    function automatic logic dfh_eol(input logic [63:0] h);
        return h[DFH_EOL_BIT];
    endfunction

    function automatic logic [23:0] dfh_next_offset(input logic [63:0] h);
        return h[DFH_NEXT_LSB +: 24];
    endfunction

    function automatic logic [3:0] dfh_major(input logic [63:0] h);
        return h[DFH_MAJOR_LSB +: 4];
    endfunction

    function automatic logic [11:0] dfh_feature_id(input logic [63:0] h);
        return h[DFH_ID_LSB +: 12];
    endfunction

    function automatic logic dfh_has_guid(input logic [63:0] h);
        return (dfh_type(h) == FT_AFU) || (dfh_type(h) == FT_BBB);
    endfunction

endpackage

// File: rtl/dfh_walker_avmm_master.sv
// Avalon-MM read master that walks a DFH chain and emits one record per feature.
// Record stream: rec_valid rises with all rec_* fields settled, and rec_valid and
// rec_* hold unchanged until a cycle with rec_valid && rec_ready (the handshake).
// Avalon reads: avm_read/avm_address hold while avm_waitrequest=1; a read is
// accepted on a cycle with avm_read && !avm_waitrequest; only one is outstanding.
module dfh_walker_avmm_master
    import dfh_pkg::*;
#(
    parameter int ADDR_WIDTH     = 20,
    parameter int MAX_FEATURES   = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            error_code,
    output logic [7:0]            feature_count,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [ADDR_WIDTH-1:0] rec_addr,
    output logic [63:0]           rec_header,
    output logic [63:0]           rec_guid_l,
    output logic [63:0]           rec_guid_h,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [63:0]           avm_readdata,
    input  logic                  avm_readdatavalid,
    output state_e                dbg_state
);

    // Sum is wide enough for both operands so any carry past ADDR_WIDTH is visible
    localparam int SUM_W = ((ADDR_WIDTH > 24) ? ADDR_WIDTH : 24) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [63:0]           hdr_q;
    logic [63:0]           guid_l_q;
    logic [63:0]           guid_h_q;
    logic [7:0]            cnt_q;
    err_e                  err_q;
    logic [TMO_W-1:0]      tmo_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  rec_valid_q;
    logic                  avm_read_q;
    logic [ADDR_WIDTH-1:0] avm_addr_q;

    logic [23:0]           next_off;
    logic [SUM_W-1:0]      link_sum;
    logic                  link_bad;
    logic [8:0]            cnt_d;
    logic                  cnt_full;
    logic [ADDR_WIDTH-1:0] base_aligned;

    // Link validation and record-count bookkeeping for the EMIT handshake
    always_comb begin
        next_off     = dfh_next_offset(hdr_q);
        link_sum     = SUM_W'(cur_addr_q) + SUM_W'(next_off);
        link_bad     = (next_off == 24'd0) || (next_off[2:0] != 3'd0)
                       || ((link_sum >> ADDR_WIDTH) != '0);
        cnt_d        = {1'b0, cnt_q} + 9'd1;
        cnt_full     = (cnt_d >= 9'(MAX_FEATURES));
        base_aligned = {base_addr[ADDR_WIDTH-1:3], 3'b000};
    end

    // Walker FSM with registered bus, stream and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            hdr_q       <= '0;
            guid_l_q    <= '0;
            guid_h_q    <= '0;
            cnt_q       <= '0;
            err_q       <= ERR_OK;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rec_valid_q <= 1'b0;
            avm_read_q  <= 1'b0;
            avm_addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cur_addr_q <= base_aligned;
                        avm_addr_q <= base_aligned;
                        avm_read_q <= 1'b1;
                        busy_q     <= 1'b1;
                        err_q      <= ERR_OK;
                        cnt_q      <= '0;
                        state_q    <= S_RD_HDR;
                    end
                end
                S_RD_HDR, S_RD_IDL, S_RD_IDH: begin
                    if (!avm_waitrequest) begin
                        avm_read_q <= 1'b0;
                        tmo_q      <= '0;
                        state_q    <= (state_q == S_RD_HDR) ? S_WT_HDR :
                                      (state_q == S_RD_IDL) ? S_WT_IDL : S_WT_IDH;
                    end
                end
                S_WT_HDR, S_WT_IDL, S_WT_IDH: begin
                    if (avm_readdatavalid) begin
                        if (state_q == S_WT_HDR) begin
                            hdr_q <= avm_readdata;
                            if (dfh_has_guid(avm_readdata)) begin
                                avm_addr_q <= cur_addr_q + ADDR_WIDTH'(8);
                                avm_read_q <= 1'b1;
                                state_q    <= S_RD_IDL;
                            end else begin
                                guid_l_q    <= '0;
                                guid_h_q    <= '0;
                                rec_valid_q <= 1'b1;
                                state_q     <= S_EMIT;
                            end
                        end else if (state_q == S_WT_IDL) begin
                            guid_l_q   <= avm_readdata;
                            avm_addr_q <= cur_addr_q + ADDR_WIDTH'(16);
                            avm_read_q <= 1'b1;
                            state_q    <= S_RD_IDH;
                        end else begin
                            guid_h_q    <= avm_readdata;
                            rec_valid_q <= 1'b1;
                            state_q     <= S_EMIT;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Abandon the feature: no record for a read that never returned
                        err_q   <= ERR_TIMEOUT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (rec_ready) begin
                        rec_valid_q <= 1'b0;
                        cnt_q       <= cnt_d[7:0];
                        if (dfh_eol(hdr_q) || link_bad || cnt_full) begin
                            err_q   <= dfh_eol(hdr_q) ? ERR_OK :
                                       link_bad       ? ERR_BAD_LINK : ERR_TOO_MANY;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            cur_addr_q <= link_sum[ADDR_WIDTH-1:0];
                            avm_addr_q <= link_sum[ADDR_WIDTH-1:0];
                            avm_read_q <= 1'b1;
                            state_q    <= S_RD_HDR;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error_code    = err_q;
    assign feature_count = cnt_q;
    assign rec_valid     = rec_valid_q;
    assign rec_addr      = cur_addr_q;
    assign rec_header    = hdr_q;
    assign rec_guid_l    = guid_l_q;
    assign rec_guid_h    = guid_h_q;
    assign avm_address   = avm_addr_q;
    assign avm_read      = avm_read_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dfh_walker_avmm_master.sv
// Directed bench for the DFH walker: memory-backed Avalon slave, record monitor,
// per-scenario tasks with inline comparisons and a single summary line.
module tb_dfh_walker_avmm_master;
    import dfh_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [19:0] base_addr = '0;
    logic        busy, done, rec_valid, rec_ready;
    logic [1:0]  error_code;
    logic [7:0]  feature_count;
    logic [19:0] rec_addr, avm_address;
    logic [63:0] rec_header, rec_guid_l, rec_guid_h, avm_readdata;
    logic        avm_read, avm_waitrequest, avm_readdatavalid;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;

    dfh_walker_avmm_master #(.ADDR_WIDTH(20), .MAX_FEATURES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .error_code(error_code), .feature_count(feature_count),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr),
        .rec_header(rec_header), .rec_guid_l(rec_guid_l), .rec_guid_h(rec_guid_h),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- Avalon slave model ----------------
    logic [63:0] mem [int];
    int          sl_wait = 0;
    int          sl_delay = 1;
    bit          sl_drop_en = 0;
    logic [19:0] sl_drop = '0;
    bit          sl_pend = 0;
    int          sl_dcnt = 0;
    int          sl_stall = 0;
    logic [19:0] sl_paddr = '0;

    initial begin
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(posedge clk); #1;
            avm_readdatavalid = 1'b0;
            avm_readdata = '0;
            if (sl_pend) begin
                sl_dcnt--;
                if (sl_dcnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = mem.exists(int'(sl_paddr)) ? mem[int'(sl_paddr)] : 64'd0;
                    sl_pend = 0;
                end
            end
            avm_waitrequest = 1'b0;
            if (avm_read && !sl_pend) begin
                if (sl_stall < sl_wait) begin
                    avm_waitrequest = 1'b1;
                    sl_stall++;
                end else begin
                    sl_stall = 0;
                    if (!(sl_drop_en && avm_address == sl_drop)) begin
                        sl_pend = 1; sl_dcnt = sl_delay; sl_paddr = avm_address;
                    end
                end
            end
        end
    end

    // ---------------- record consumer ----------------
    bit rdy_stall = 0;
    int rdy_low = 0;
    initial begin
        rec_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!rec_valid) begin
                rdy_low = 0; rec_ready = !rdy_stall;
            end else if (rdy_stall && rdy_low < 10) begin
                rec_ready = 1'b0; rdy_low++;
            end else begin
                rec_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard capture ----------------
    logic [19:0] obs_addr_q[$];
    logic [63:0] obs_hdr_q[$], obs_gl_q[$], obs_gh_q[$];
    logic [19:0] rd_q[$];
    logic [19:0] exp_q[$];
    int done_cnt = 0, done_cyc = 0, acc_cyc = 0, first_rv = -1, first_rd = -1;
    logic done_busy = 1'b0;
    int unstable = 0, rv_stall_cyc = 0, wr_stall_cyc = 0;
    bit p_rv_stall = 0, p_wr_stall = 0;
    logic [19:0] p_raddr, p_avma;
    logic [63:0] p_hdr, p_gl, p_gh;

    initial forever begin
        @(negedge clk);
        if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end
        if (rec_valid && first_rv < 0) first_rv = cyc;
        if (avm_read && first_rd < 0) first_rd = cyc;
        if (p_rv_stall && (rec_valid !== 1'b1 || rec_addr !== p_raddr || rec_header !== p_hdr
                           || rec_guid_l !== p_gl || rec_guid_h !== p_gh)) unstable++;
        if (p_wr_stall && (avm_read !== 1'b1 || avm_address !== p_avma)) unstable++;
        p_rv_stall = rec_valid && !rec_ready;
        p_wr_stall = avm_read && avm_waitrequest;
        if (p_rv_stall) rv_stall_cyc++;
        if (p_wr_stall) wr_stall_cyc++;
        p_raddr = rec_addr; p_hdr = rec_header; p_gl = rec_guid_l; p_gh = rec_guid_h;
        p_avma = avm_address;
        if (rec_valid && rec_ready) begin
            obs_addr_q.push_back(rec_addr); obs_hdr_q.push_back(rec_header);
            obs_gl_q.push_back(rec_guid_l); obs_gh_q.push_back(rec_guid_h);
        end
        if (avm_read && !avm_waitrequest) begin rd_q.push_back(avm_address); acc_cyc = cyc; end
    end

    // ---------------- driver tasks ----------------
    int t0 = 0, done_base = 0;

    task automatic clear_obs();
        obs_addr_q.delete(); obs_hdr_q.delete(); obs_gl_q.delete(); obs_gh_q.delete();
        rd_q.delete(); exp_q.delete();
        first_rv = -1; first_rd = -1; unstable = 0; rv_stall_cyc = 0; wr_stall_cyc = 0;
        done_base = done_cnt;
    endtask

    task automatic start_walk(input logic [19:0] a);
        @(posedge clk); #1;
        base_addr = a; start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin @(posedge clk); n++; end
        checks++;
        if (done_cnt == done_base) begin
            errors++; $display("FAIL %s_done_timeout no done within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (error_code !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", error_code); end
        checks++; if (feature_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d want 0", feature_count); end
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL rst_rec_valid got %b want 0", rec_valid); end
        checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL rst_avm_read got %b want 0", avm_read); end
        checks++; if (avm_address !== 20'd0) begin errors++; $display("FAIL rst_avm_address got %h want 0", avm_address); end
        checks++; if (rec_addr !== 20'd0) begin errors++; $display("FAIL rst_rec_addr got %h want 0", rec_addr); end
        checks++; if (rec_header !== 64'd0) begin errors++; $display("FAIL rst_rec_header got %h want 0", rec_header); end
        checks++; if (rec_guid_l !== 64'd0 || rec_guid_h !== 64'd0) begin
            errors++; $display("FAIL rst_guid got %h/%h want 0/0", rec_guid_l, rec_guid_h); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_state got %0d want IDLE", dbg_state); end
    endtask

    task automatic test_single_afu();
        mem.delete();
        mem[0] = 64'h1000_0100_0000_0000;
        mem[8] = 64'h9081_F88B_8F65_5CAA;
        mem[16] = 64'h331D_B30C_9885_41EA;
        clear_obs();
        exp_q = '{20'h0, 20'h8, 20'h10};
        start_walk(20'h0);
        wait_done(60, "single");
        checks++; if (first_rd - t0 !== 1) begin errors++; $display("FAIL single_first_read_cycle got %0d want 1", first_rd - t0); end
        checks++; if (first_rv - t0 !== 7) begin errors++; $display("FAIL single_rec_valid_cycle got %0d want 7", first_rv - t0); end
        checks++; if (done_cyc - t0 !== 8) begin errors++; $display("FAIL single_done_cycle got %0d want 8", done_cyc - t0); end
        checks++; if (done_cnt - done_base !== 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", done_cnt - done_base); end
        checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_done got %b want 0", done_busy); end
        checks++; if (obs_addr_q.size() !== 1) begin
            errors++; $display("FAIL single_records got %0d want 1", obs_addr_q.size());
        end else begin
            checks++; if (obs_addr_q[0] !== 20'h0) begin errors++; $display("FAIL single_addr got %h want 0", obs_addr_q[0]); end
            checks++; if (obs_hdr_q[0] !== 64'h1000_0100_0000_0000) begin errors++; $display("FAIL single_header got %h want 1000010000000000", obs_hdr_q[0]); end
            checks++; if (obs_gl_q[0] !== 64'h9081_F88B_8F65_5CAA) begin errors++; $display("FAIL single_guid_l got %h want 9081f88b8f655caa", obs_gl_q[0]); end
            checks++; if (obs_gh_q[0] !== 64'h331D_B30C_9885_41EA) begin errors++; $display("FAIL single_guid_h got %h want 331db30c988541ea", obs_gh_q[0]); end
        end
        checks++; if (feature_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d want 1", feature_count); end
        checks++; if (error_code !== 2'b00) begin errors++; $display("FAIL single_err got %b want 00", error_code); end
        checks++; if (rd_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL single_reads got %0d want %0d", rd_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (rd_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_read_addr[%0d] got %h want %h", i, rd_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_chain(input bit stall);
        logic [63:0] eh[3], egl[3], egh[3];
        logic [19:0] ea[3];
        string nm;
        nm = stall ? "stall" : "chain";
        mem.delete();
        mem[32'h000] = 64'h1000_0000_0100_0001;
        mem[32'h008] = 64'h1111_0000_AAAA_0001;
        mem[32'h010] = 64'h2222_0000_BBBB_0001;
        mem[32'h100] = 64'h3000_0000_0080_0002;
        mem[32'h108] = 64'hDEAD_BEEF_DEAD_BEEF;
        mem[32'h110] = 64'hDEAD_BEEF_DEAD_BEEF;
        mem[32'h180] = 64'h2000_0100_0000_0003;
        mem[32'h188] = 64'h3333_0000_CCCC_0003;
        mem[32'h190] = 64'h4444_0000_DDDD_0003;
        ea  = '{20'h000, 20'h100, 20'h180};
        eh  = '{64'h1000_0000_0100_0001, 64'h3000_0000_0080_0002, 64'h2000_0100_0000_0003};
        egl = '{64'h1111_0000_AAAA_0001, 64'h0, 64'h3333_0000_CCCC_0003};
        egh = '{64'h2222_0000_BBBB_0001, 64'h0, 64'h4444_0000_DDDD_0003};
        sl_wait = stall ? 5 : 0;
        sl_delay = stall ? 7 : 1;
        rdy_stall = stall;
        clear_obs();
        exp_q = '{20'h000, 20'h008, 20'h010, 20'h100, 20'h180, 20'h188, 20'h190};
        start_walk(20'h0);
        wait_done(600, nm);
        checks++; if (obs_addr_q.size() !== 3) begin
            errors++; $display("FAIL %s_records got %0d want 3", nm, obs_addr_q.size());
        end else for (int i = 0; i < 3; i++) begin
            checks++; if (obs_addr_q[i] !== ea[i] || obs_hdr_q[i] !== eh[i] || obs_gl_q[i] !== egl[i] || obs_gh_q[i] !== egh[i]) begin
                errors++;
                $display("FAIL %s_rec[%0d] got %h %h %h %h want %h %h %h %h", nm, i,
                         obs_addr_q[i], obs_hdr_q[i], obs_gl_q[i], obs_gh_q[i], ea[i], eh[i], egl[i], egh[i]);
            end
        end
        checks++; if (rd_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL %s_reads got %0d want %0d", nm, rd_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (rd_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_read_addr[%0d] got %h want %h", nm, i, rd_q[i], exp_q[i]); end
        end
        checks++; if (feature_count !== 8'd3) begin errors++; $display("FAIL %s_count got %0d want 3", nm, feature_count); end
        checks++; if (error_code !== 2'b00) begin errors++; $display("FAIL %s_err got %b want 00", nm, error_code); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL %s_stability got %0d changes want 0", nm, unstable); end
        if (stall) begin
            checks++; if (rv_stall_cyc < 30) begin errors++; $display("FAIL stall_ready_low got %0d cycles want >=30", rv_stall_cyc); end
            checks++; if (wr_stall_cyc < 35) begin errors++; $display("FAIL stall_waitrequest got %0d cycles want >=35", wr_stall_cyc); end
        end
        sl_wait = 0; sl_delay = 1; rdy_stall = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_timeout();
        mem.delete();
        mem[0] = 64'h1000_0100_0000_0000;
        mem[8] = 64'h0123_4567_89AB_CDEF;
        sl_drop_en = 1; sl_drop = 20'h10;
        clear_obs();
        start_walk(20'h0);
        wait_done(100, "timeout");
        checks++; if (error_code !== 2'b01) begin errors++; $display("FAIL timeout_err got %b want 01", error_code); end
        checks++; if (feature_count !== 8'd0) begin errors++; $display("FAIL timeout_count got %0d want 0", feature_count); end
        checks++; if (obs_addr_q.size() !== 0) begin errors++; $display("FAIL timeout_records got %0d want 0", obs_addr_q.size()); end
        checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_at_done got %b want 0", done_busy); end
        checks++; if (rd_q.size() == 0 || rd_q[rd_q.size()-1] !== 20'h10) begin
            errors++; $display("FAIL timeout_last_read got %0d reads want last at 10", rd_q.size()); end
        checks++; if (done_cyc - acc_cyc > 18 || done_cyc - acc_cyc < 16) begin
            errors++; $display("FAIL timeout_latency got %0d cycles want 16..18", done_cyc - acc_cyc); end
        sl_drop_en = 0;
    endtask

    task automatic test_bad_link();
        logic [63:0] hv[3];
        logic [19:0] bv[3];
        hv = '{64'h3000_0000_0000_0005, 64'h3000_0000_0104_0006, 64'h3000_0000_0200_0007};
        bv = '{20'h00000, 20'h00000, 20'hFFF00};
        for (int k = 0; k < 3; k++) begin
            mem.delete();
            mem[int'(bv[k])] = hv[k];
            clear_obs();
            start_walk(bv[k]);
            wait_done(60, "badlink");
            checks++; if (error_code !== 2'b10) begin errors++; $display("FAIL badlink%0d_err got %b want 10", k, error_code); end
            checks++; if (feature_count !== 8'd1) begin errors++; $display("FAIL badlink%0d_count got %0d want 1", k, feature_count); end
            checks++; if (obs_addr_q.size() !== 1 || rd_q.size() !== 1) begin
                errors++; $display("FAIL badlink%0d_traffic got %0d records %0d reads want 1 1", k, obs_addr_q.size(), rd_q.size());
            end else begin
                checks++; if (obs_addr_q[0] !== bv[k] || obs_gl_q[0] !== 64'd0) begin
                    errors++; $display("FAIL badlink%0d_rec got %h %h want %h 0", k, obs_addr_q[0], obs_gl_q[0], bv[k]); end
            end
        end
    endtask

    task automatic test_max_features();
        mem.delete();
        for (int a = 0; a <= 64; a += 8) mem[a] = 64'h3000_0000_0008_0000;
        clear_obs();
        exp_q = '{20'h00, 20'h08, 20'h10, 20'h18};
        start_walk(20'h0);
        wait_done(100, "max");
        checks++; if (error_code !== 2'b11) begin errors++; $display("FAIL max_err got %b want 11", error_code); end
        checks++; if (feature_count !== 8'd4) begin errors++; $display("FAIL max_count got %0d want 4", feature_count); end
        checks++; if (obs_addr_q.size() !== 4 || rd_q.size() !== 4) begin
            errors++; $display("FAIL max_traffic got %0d records %0d reads want 4 4", obs_addr_q.size(), rd_q.size());
        end else foreach (exp_q[i]) begin
            checks++; if (obs_addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL max_rec_addr[%0d] got %h want %h", i, obs_addr_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_walk();
        int n = 0;
        mem.delete();
        mem[0] = 64'h1000_0100_0000_0000;
        mem[8] = 64'hAAAA_5555_AAAA_5555;
        mem[16] = 64'h5555_AAAA_5555_AAAA;
        sl_delay = 4;
        clear_obs();
        start_walk(20'h0);
        while (rd_q.size() < 2 && n < 60) begin @(negedge clk); n++; end
        checks++; if (rd_q.size() < 2) begin errors++; $display("FAIL midrst_guid_read got %0d reads want 2", rd_q.size()); end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (dbg_state !== S_WT_IDL) begin errors++; $display("FAIL midrst_state got %0d want WT_IDL", dbg_state); end
        @(posedge clk); #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0 || rec_valid !== 1'b0 || avm_read !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl got busy %b rv %b rd %b want 0 0 0", busy, rec_valid, avm_read); end
        checks++; if (error_code !== 2'b00 || feature_count !== 8'd0) begin
            errors++; $display("FAIL midrst_status got %b %0d want 00 0", error_code, feature_count); end
        checks++; if (rec_guid_l !== 64'd0 || rec_header !== 64'd0 || avm_address !== 20'd0) begin
            errors++; $display("FAIL midrst_data got %h %h %h want 0 0 0", rec_guid_l, rec_header, avm_address); end
        checks++; if (done_cnt !== done_base || obs_addr_q.size() !== 0) begin
            errors++; $display("FAIL midrst_no_done got %0d pulses %0d records want 0 0", done_cnt - done_base, obs_addr_q.size()); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL midrst_idle got %0d want IDLE", dbg_state); end
        sl_delay = 1;
        clear_obs();
        start_walk(20'h0);
        wait_done(60, "midrst_rewalk");
        checks++; if (done_cyc - t0 !== 8) begin errors++; $display("FAIL midrst_rewalk_done_cycle got %0d want 8", done_cyc - t0); end
        checks++; if (error_code !== 2'b00 || feature_count !== 8'd1) begin
            errors++; $display("FAIL midrst_rewalk_status got %b %0d want 00 1", error_code, feature_count); end
        checks++; if (obs_gh_q.size() !== 1 || obs_gh_q[0] !== 64'h5555_AAAA_5555_AAAA) begin
            errors++; $display("FAIL midrst_rewalk_guid_h got %0d records want one with 5555aaaa5555aaaa", obs_gh_q.size()); end
    endtask

    task automatic test_start_while_busy();
        mem.delete();
        mem[0] = 64'h1000_0100_0000_0000;
        mem[32'h40] = 64'h3000_0100_0000_0009;
        sl_delay = 3;
        clear_obs();
        start_walk(20'h0);
        @(posedge clk); #1 base_addr = 20'h40; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(80, "busy_start");
        checks++; if (obs_addr_q.size() !== 1 || obs_addr_q[0] !== 20'h0) begin
            errors++; $display("FAIL busy_start_rec got %0d records want one at 0", obs_addr_q.size()); end
        checks++; if (rd_q.size() !== 3) begin errors++; $display("FAIL busy_start_reads got %0d want 3", rd_q.size()); end
        sl_delay = 1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_afu();
        test_chain(1'b0);
        test_chain(1'b1);
        test_timeout();
        test_bad_link();
        test_max_features();
        test_reset_mid_walk();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
